wb_stage: RTL and testbench

- Writeback stage of the sorting pipeline: MEM/WB pipeline register, load-data extraction, writeback-source mux, and arbitration of the register file's single write port.
- Two write sources: the in-order pipeline result, and a long-latency multiply/divide (MD) unit through a valid/ready handshake with a 1-entry holding buffer.
- Drives the register file write port and the WB-stage forwarding bus.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_stage_load_extract.sv | 42 ++++
 rtl/wb_stage.sv | 176 +++++++++++++++++
 tb/tb_wb_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: writeback-source select and load types.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wb_pkg;

    // Writeback source select (mem_wb_sel); 2'b11 is reserved and treated as ALU.
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    // Load type encodings (mem_load_type); anything else behaves as a word load.
    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Little-endian load-data extraction: picks byte/halfword/word from a raw memory word and extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: raw_word (memory word), offset (byte address bits [1:0]), load_type, load_data (extended result).
module load_extract
    import wb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] raw_word,
    input  logic [1:0]    offset,
    input  logic [2:0]    load_type,
    output logic [DW-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_word[7:0];
        case (offset)
            2'd0:    byte_sel = raw_word[7:0];
            2'd1:    byte_sel = raw_word[15:8];
            2'd2:    byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase

        // Halfword lanes follow offset[1] only; offset[0] is ignored, so misaligned halfwords never trap.
        half_sel = offset[1] ? raw_word[31:16] : raw_word[15:0];

        load_data = raw_word;
        case (load_type)
            LD_LW:   load_data = raw_word;
            LD_LB:   load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  load_data = {{(DW-8){1'b0}}, byte_sel};
            LD_LH:   load_data = {{(DW-16){half_sel[15]}}, half_sel};
            LD_LHU:  load_data = {{(DW-16){1'b0}}, half_sel};
            default: load_data = raw_word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, and arbitration of the single RF write port
// between the in-order pipeline and a 1-entry buffered multiply/divide result.
// Latency: 1 cycle MEM->RF port; MD result reaches the port the cycle after acceptance at the earliest.
// Backpressure: md_ready drops while the MD buffer is occupied; pipeline writes always win the port.
// Ports: clk/reset (async active-low); stall/flush control MEM/WB; mem_* MEM-stage inputs;
//        md_valid/md_rd/md_data/md_ready MD handshake; rf_* write port; fwd_* forwarding bus; md_pending.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_rd,
    input  logic [1:0]    mem_wb_sel,
    input  logic [2:0]    mem_load_type,
    input  logic [DW-1:0] mem_alu_result,
    input  logic [DW-1:0] mem_read_data,
    input  logic [DW-1:0] mem_pc_plus4,
    input  logic          md_valid,
    input  logic [AW-1:0] md_rd,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data,
    output logic          md_pending
);

    // MEM/WB pipeline register
    logic          wb_reg_write_q, wb_reg_write_d;
    logic [AW-1:0] wb_rd_q,        wb_rd_d;
    logic [1:0]    wb_sel_q,       wb_sel_d;
    logic [2:0]    wb_load_type_q, wb_load_type_d;
    logic [DW-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [DW-1:0] wb_read_data_q, wb_read_data_d;
    logic [DW-1:0] wb_pc_plus4_q,  wb_pc_plus4_d;

    // MD holding buffer
    logic          md_pending_q, md_pending_d;
    logic [AW-1:0] md_rd_q,      md_rd_d;
    logic [DW-1:0] md_data_q,    md_data_d;

    logic [DW-1:0] load_data;
    logic [DW-1:0] pipe_data;
    logic          pipe_wr;
    logic          md_accept;
    logic          md_release;

    load_extract #(.DW(DW)) u_load_extract (
        .raw_word  (wb_read_data_q),
        .offset    (wb_alu_result_q[1:0]),
        .load_type (wb_load_type_q),
        .load_data (load_data)
    );

    // MEM/WB next state: flush beats stall.
    always_comb begin
        wb_reg_write_d  = mem_reg_write;
        wb_rd_d         = mem_rd;
        wb_sel_d        = mem_wb_sel;
        wb_load_type_d  = mem_load_type;
        wb_alu_result_d = mem_alu_result;
        wb_read_data_d  = mem_read_data;
        wb_pc_plus4_d   = mem_pc_plus4;
        if (flush) begin
            wb_reg_write_d  = 1'b0;
            wb_rd_d         = '0;
            wb_sel_d        = '0;
            wb_load_type_d  = '0;
            wb_alu_result_d = '0;
            wb_read_data_d  = '0;
            wb_pc_plus4_d   = '0;
        end else if (stall) begin
            wb_reg_write_d  = wb_reg_write_q;
            wb_rd_d         = wb_rd_q;
            wb_sel_d        = wb_sel_q;
            wb_load_type_d  = wb_load_type_q;
            wb_alu_result_d = wb_alu_result_q;
            wb_read_data_d  = wb_read_data_q;
            wb_pc_plus4_d   = wb_pc_plus4_q;
        end
    end

    // Writeback source mux; reserved encoding falls through to ALU.
    always_comb begin
        pipe_data = wb_alu_result_q;
        case (wb_sel_q)
            WB_SEL_ALU:  pipe_data = wb_alu_result_q;
            WB_SEL_LOAD: pipe_data = load_data;
            WB_SEL_LINK: pipe_data = wb_pc_plus4_q;
            default:     pipe_data = wb_alu_result_q;
        endcase
    end

    assign pipe_wr   = wb_reg_write_q && (wb_rd_q != '0);
    assign md_ready  = !md_pending_q;
    assign md_accept = md_valid && md_ready;

    // Port arbitration. The pipeline always owns the port when it writes; the MD entry is released
    // either by using a free port (writes only if rd!=0) or by being overtaken by a younger pipeline
    // write to the same register, which makes its value dead.
    always_comb begin
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        md_release = 1'b0;
        if (pipe_wr) begin
            rf_we      = 1'b1;
            rf_waddr   = wb_rd_q;
            rf_wdata   = pipe_data;
            md_release = md_pending_q && (md_rd_q == wb_rd_q);
        end else if (md_pending_q) begin
            md_release = 1'b1;
            if (md_rd_q != '0) begin
                rf_we    = 1'b1;
                rf_waddr = md_rd_q;
                rf_wdata = md_data_q;
            end
        end
    end

    // Acceptance only happens while empty, so it never coincides with a release: no same-cycle refill.
    always_comb begin
        md_pending_d = md_pending_q;
        md_rd_d      = md_rd_q;
        md_data_d    = md_data_q;
        if (md_accept) begin
            md_pending_d = 1'b1;
            md_rd_d      = md_rd;
            md_data_d    = md_data;
        end else if (md_release) begin
            md_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_reg_write_q  <= 1'b0;
            wb_rd_q         <= '0;
            wb_sel_q        <= '0;
            wb_load_type_q  <= '0;
            wb_alu_result_q <= '0;
            wb_read_data_q  <= '0;
            wb_pc_plus4_q   <= '0;
            md_pending_q    <= 1'b0;
            md_rd_q         <= '0;
            md_data_q       <= '0;
        end else begin
            wb_reg_write_q  <= wb_reg_write_d;
            wb_rd_q         <= wb_rd_d;
            wb_sel_q        <= wb_sel_d;
            wb_load_type_q  <= wb_load_type_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_pc_plus4_q   <= wb_pc_plus4_d;
            md_pending_q    <= md_pending_d;
            md_rd_q         <= md_rd_d;
            md_data_q       <= md_data_d;
        end
    end

    // MD writes are deliberately not forwarded; the hazard unit covers them via md_pending.
    assign fwd_valid  = pipe_wr;
    assign fwd_rd     = wb_rd_q;
    assign fwd_data   = pipe_data;
    assign md_pending = md_pending_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected port state is queued when inputs are driven and
// compared one clock later, after the edge that makes it visible.
// Latency: n/a. Backpressure: the MD driver only offers results as the directed steps dictate.
module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall, flush;
    logic          mem_reg_write;
    logic [AW-1:0] mem_rd;
    logic [1:0]    mem_wb_sel;
    logic [2:0]    mem_load_type;
    logic [DW-1:0] mem_alu_result, mem_read_data, mem_pc_plus4;
    logic          md_valid;
    logic [AW-1:0] md_rd;
    logic [DW-1:0] md_data;
    logic          md_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
    logic          md_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         tag;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          fv;
        logic          mp;
        logic          mr;
    } exp_t;

    exp_t sb[$];

    wb_stage #(.DW(DW), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_wb_sel     (mem_wb_sel),
        .mem_load_type  (mem_load_type),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .mem_pc_plus4   (mem_pc_plus4),
        .md_valid       (md_valid),
        .md_rd          (md_rd),
        .md_data        (md_data),
        .md_ready       (md_ready),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .md_pending     (md_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Compare all observable port state against one expectation.
    task automatic compare(input exp_t e);
        check({e.tag, ".rf_we"},      DW'(rf_we),      DW'(e.we));
        check({e.tag, ".rf_waddr"},   DW'(rf_waddr),   DW'(e.waddr));
        check({e.tag, ".rf_wdata"},   rf_wdata,        e.wdata);
        check({e.tag, ".fwd_valid"},  DW'(fwd_valid),  DW'(e.fv));
        check({e.tag, ".md_pending"}, DW'(md_pending), DW'(e.mp));
        check({e.tag, ".md_ready"},   DW'(md_ready),   DW'(e.mr));
        if (e.fv) begin
            check({e.tag, ".fwd_rd"},   DW'(fwd_rd), DW'(e.waddr));
            check({e.tag, ".fwd_data"}, fwd_data,    e.wdata);
        end
    endtask

    // Queue the expectation for the currently driven inputs, advance one clock, then check.
    task automatic step(input string tag, input logic we, input logic [AW-1:0] waddr,
                        input logic [DW-1:0] wdata, input logic fv, input logic mp, input logic mr);
        exp_t e;
        e.tag = tag; e.we = we; e.waddr = waddr; e.wdata = wdata; e.fv = fv; e.mp = mp; e.mr = mr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty at compare", tag);
        end else begin
            compare(sb.pop_front());
        end
    endtask

    task automatic pipe(input logic rw, input logic [AW-1:0] rd, input logic [1:0] sel,
                        input logic [2:0] lt, input logic [DW-1:0] alu);
        mem_reg_write  = rw;
        mem_rd         = rd;
        mem_wb_sel     = sel;
        mem_load_type  = lt;
        mem_alu_result = alu;
    endtask

    task automatic md(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        md_valid = v;
        md_rd    = rd;
        md_data  = d;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        pipe(1'b0, '0, 2'b00, 3'b000, '0);
        mem_read_data = 32'h80FF7F01;
        mem_pc_plus4  = 32'h0000_1004;
        md(1'b0, '0, '0);

        // Reset state, including an edge with reset held.
        #2;
        step("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;

        // Basic ALU write and forwarding.
        pipe(1'b1, 5'd5, 2'b00, 3'b000, 32'h12345678);
        step("alu_rd5", 1'b1, 5'd5, 32'h12345678, 1'b1, 1'b0, 1'b1);

        // Load extraction from word 0x80FF7F01.
        pipe(1'b1, 5'd6, 2'b01, 3'b001, 32'h1);
        step("lb_off1", 1'b1, 5'd6, 32'h0000007F, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd6, 2'b01, 3'b001, 32'h2);
        step("lb_off2", 1'b1, 5'd6, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd6, 2'b01, 3'b010, 32'h3);
        step("lbu_off3", 1'b1, 5'd6, 32'h00000080, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd6, 2'b01, 3'b011, 32'h2);
        step("lh_off2", 1'b1, 5'd6, 32'hFFFF80FF, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd6, 2'b01, 3'b011, 32'h3);
        step("lh_off3", 1'b1, 5'd6, 32'hFFFF80FF, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd6, 2'b01, 3'b100, 32'h0);
        step("lhu_off0", 1'b1, 5'd6, 32'h00007F01, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd6, 2'b01, 3'b000, 32'h0);
        step("lw", 1'b1, 5'd6, 32'h80FF7F01, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd6, 2'b01, 3'b111, 32'h1);
        step("ld_undef", 1'b1, 5'd6, 32'h80FF7F01, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd1, 2'b10, 3'b000, 32'h55);
        step("link", 1'b1, 5'd1, 32'h00001004, 1'b1, 1'b0, 1'b1);
        pipe(1'b1, 5'd2, 2'b11, 3'b000, 32'h66);
        step("sel_rsvd", 1'b1, 5'd2, 32'h00000066, 1'b1, 1'b0, 1'b1);

        // Write to x0 is suppressed.
        pipe(1'b1, 5'd0, 2'b00, 3'b000, 32'hABCD);
        step("rd0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // MD result during a bubble: buffered, written next cycle, then ready again.
        pipe(1'b0, 5'd0, 2'b00, 3'b000, 32'h0);
        md(1'b1, 5'd9, 32'hDEADBEEF);
        step("md_accept", 1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        md(1'b0, '0, '0);
        step("md_done", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // MD rd=9 waits behind three cycles of pipeline rd=4; rd=10 offered while not ready.
        pipe(1'b1, 5'd4, 2'b00, 3'b000, 32'h44);
        md(1'b1, 5'd9, 32'hCAFEF00D);
        step("busy1", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        md(1'b1, 5'd10, 32'h10101010);
        step("busy2", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 1'b0);
        step("busy3", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        step("flush_stall", 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        flush = 1'b0;
        pipe(1'b0, 5'd0, 2'b00, 3'b000, 32'h0);
        step("md9_retired", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        step("md10_accept", 1'b1, 5'd10, 32'h10101010, 1'b0, 1'b1, 1'b0);
        md(1'b0, '0, '0);
        step("md10_done", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // WAW: younger pipeline write to rd=7 kills the buffered MD result.
        pipe(1'b1, 5'd7, 2'b00, 3'b000, 32'h1);
        md(1'b1, 5'd7, 32'h77777777);
        step("waw", 1'b1, 5'd7, 32'h1, 1'b1, 1'b1, 1'b0);
        md(1'b0, '0, '0);
        pipe(1'b0, 5'd0, 2'b00, 3'b000, 32'h0);
        step("waw_drop", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        step("waw_quiet", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // MD to x0 retires silently.
        md(1'b1, 5'd0, 32'h12121212);
        step("md_rd0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        md(1'b0, '0, '0);
        step("md_rd0_done", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset mid-operation discards the pending MD result immediately.
        pipe(1'b1, 5'd4, 2'b00, 3'b000, 32'h44);
        md(1'b1, 5'd12, 32'h000000AB);
        step("pre_reset", 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 1'b0);
        md(1'b0, '0, '0);
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("rst_async.rf_we",      DW'(rf_we),      DW'(1'b0));
        check("rst_async.md_pending", DW'(md_pending), DW'(1'b0));
        check("rst_async.md_ready",   DW'(md_ready),   DW'(1'b1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        stall = 1'b0;
        pipe(1'b0, 5'd0, 2'b00, 3'b000, 32'h0);
        step("post_reset1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        step("post_reset2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        check("sb_empty", DW'(sb.size()), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
